// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the add/sub sequencer and its arbiter.
package fp_addsub_pkg;

  localparam int unsigned PKG_FLEN  = 32;
  localparam int unsigned PKG_TAG_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int unsigned FFLAG_NV = 4;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_NX = 0;

  typedef struct packed {
    logic [PKG_FLEN-1:0]  a;
    logic [PKG_FLEN-1:0]  b;
    logic                 sub;
    logic [2:0]           rm;
    logic [PKG_TAG_W-1:0] tag;
  } addsub_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips to the other port after every grant.
module rr_arb2
  import fp_addsub_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt0  = en & req0 & (~req1 | ~ptr_q);
    gnt1  = en & req1 & (~req0 | ptr_q);
    ptr_d = ptr_q;
    if (gnt0)      ptr_d = 1'b1;
    else if (gnt1) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequencer for the shared FP add/sub datapath: arbitrates two requesters, steps
// the stage enables, bypasses special operands and holds the response until taken.
//   state | meaning
//   IDLE  | waiting for a request
//   ALIGN | unpack/align; dp_special sampled here
//   ADD   | mantissa add
//   NORM  | normalize
//   ROUND | round; result captured on exit
//   DONE  | response presented until resp_ready
module fp_addsub_seq
  import fp_addsub_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int FLEN  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [FLEN-1:0]  req0_a,
  input  logic [FLEN-1:0]  req0_b,
  input  logic             req0_sub,
  input  logic [2:0]       req0_rm,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [FLEN-1:0]  req1_a,
  input  logic [FLEN-1:0]  req1_b,
  input  logic             req1_sub,
  input  logic [2:0]       req1_rm,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [FLEN-1:0]  dp_a,
  output logic [FLEN-1:0]  dp_b,
  output logic             dp_sub,
  output logic [2:0]       dp_rm,
  output logic             st_align_en,
  output logic             st_add_en,
  output logic             st_norm_en,
  output logic             st_round_en,
  input  logic             dp_special,
  input  logic [FLEN-1:0]  dp_result,
  input  logic [4:0]       dp_fflags,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [FLEN-1:0]  resp_result,
  output logic [4:0]       resp_fflags,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_src,
  output logic             busy
);

  seq_state_e       state_q, state_d;
  logic [FLEN-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic             sub_q, sub_d, src_q, src_d;
  logic [2:0]       rm_q, rm_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [4:0]       flags_q, flags_d;
  logic             accept_en, gnt0, gnt1;

  assign accept_en = (state_q == S_IDLE) & ~flush;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (accept_en),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    rm_d    = rm_q;
    tag_d   = tag_q;
    src_d   = src_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt0 | gnt1) begin
            state_d = S_ALIGN;
            a_d     = gnt1 ? req1_a   : req0_a;
            b_d     = gnt1 ? req1_b   : req0_b;
            sub_d   = gnt1 ? req1_sub : req0_sub;
            rm_d    = gnt1 ? req1_rm  : req0_rm;
            tag_d   = gnt1 ? req1_tag : req0_tag;
            src_d   = gnt1;
          end
        end
        S_ALIGN: begin
          if (dp_special) begin
            state_d = S_DONE;
            res_d   = dp_result;
            flags_d = dp_fflags;
          end else begin
            state_d = S_ADD;
          end
        end
        S_ADD:   state_d = S_NORM;
        S_NORM:  state_d = S_ROUND;
        S_ROUND: begin
          state_d = S_DONE;
          res_d   = dp_result;
          flags_d = dp_fflags;
        end
        S_DONE:  if (resp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      rm_q    <= '0;
      tag_q   <= '0;
      src_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      rm_q    <= rm_d;
      tag_q   <= tag_d;
      src_q   <= src_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign dp_a        = a_q;
  assign dp_b        = b_q;
  assign dp_sub      = sub_q;
  assign dp_rm       = rm_q;
  assign st_align_en = (state_q == S_ALIGN);
  assign st_add_en   = (state_q == S_ADD);
  assign st_norm_en  = (state_q == S_NORM);
  assign st_round_en = (state_q == S_ROUND);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = res_q;
  assign resp_fflags = flags_q;
  assign resp_tag    = tag_q;
  assign resp_src    = src_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Bench for fp_addsub_seq: scenario tasks plus randomized traffic against a
// round-robin/latency reference model and a stub datapath.
module tb_fp_addsub_seq;
  import fp_addsub_pkg::*;

  localparam int TAG_W = 5;
  localparam int FLEN  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, flush;
  logic             req0_valid, req0_ready, req0_sub;
  logic [FLEN-1:0]  req0_a, req0_b;
  logic [2:0]       req0_rm;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_sub;
  logic [FLEN-1:0]  req1_a, req1_b;
  logic [2:0]       req1_rm;
  logic [TAG_W-1:0] req1_tag;
  logic [FLEN-1:0]  dp_a, dp_b, dp_result, resp_result;
  logic             dp_sub, dp_special;
  logic [2:0]       dp_rm;
  logic             st_align_en, st_add_en, st_norm_en, st_round_en;
  logic [4:0]       dp_fflags, resp_fflags;
  logic             resp_valid, resp_ready, resp_src, busy;
  logic [TAG_W-1:0] resp_tag;

  fp_addsub_seq #(.TAG_W(TAG_W), .FLEN(FLEN)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sub(req0_sub), .req0_rm(req0_rm), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sub(req1_sub), .req1_rm(req1_rm), .req1_tag(req1_tag),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sub(dp_sub), .dp_rm(dp_rm),
    .st_align_en(st_align_en), .st_add_en(st_add_en), .st_norm_en(st_norm_en),
    .st_round_en(st_round_en), .dp_special(dp_special), .dp_result(dp_result),
    .dp_fflags(dp_fflags), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_fflags(resp_fflags), .resp_tag(resp_tag),
    .resp_src(resp_src), .busy(busy)
  );

  // Stub datapath: a fixed answer per operand set, only valid in the capture cycle.
  function automatic logic [36:0] dp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [2:0] rm);
    logic [31:0] r;
    logic [4:0]  f;
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) begin
      r = 32'h40400000; f = 5'd0;
    end else if (a[30:23] == 8'hFF) begin
      r = a | 32'h00400000; f = {~a[22], 4'b0};
    end else begin
      r = sub ? a - b : a + b; f = {rm, sub, a[0]};
    end
    return {f, r};
  endfunction

  logic [36:0] dp_out;
  logic        dp_window;
  assign dp_special = st_align_en & (dp_a[30:23] == 8'hFF);
  assign dp_window  = st_round_en | (st_align_en & dp_special);
  assign dp_out     = dp_model(dp_a, dp_b, dp_sub, dp_rm);
  assign dp_result  = dp_window ? dp_out[31:0]  : 32'hDEADBEEF;
  assign dp_fflags  = dp_window ? dp_out[36:32] : 5'h1F;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit exp_ptr  = 1'b0;

  function automatic int rr_pick(input bit v0, input bit v1, input bit ptr);
    if (v0 && v1) return int'(ptr);
    return v0 ? 0 : 1;
  endfunction

  function automatic int exp_latency(input addsub_req_t r);
    return (r.a[30:23] == 8'hFF) ? 2 : 5;
  endfunction

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic clear_reqs;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic drive_req(input int port, input addsub_req_t r);
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = r.a; req0_b = r.b; req0_sub = r.sub; req0_rm = r.rm; req0_tag = r.tag;
    end else begin
      req1_valid = 1'b1; req1_a = r.a; req1_b = r.b; req1_sub = r.sub; req1_rm = r.rm; req1_tag = r.tag;
    end
  endtask

  task automatic rand_req(output addsub_req_t r, input bit special);
    r.a = $urandom;
    if (special) r.a[30:23] = 8'hFF;
    else if (r.a[30:23] == 8'hFF) r.a[30] = 1'b0;
    r.b   = $urandom;
    r.sub = 1'($urandom_range(0, 1));
    r.rm  = 3'($urandom_range(0, 4));
    r.tag = 5'($urandom_range(0, 31));
  endtask

  task automatic do_reset;
    clear_reqs(); flush = 1'b0; resp_ready = 1'b0;
    reset_n = 1'b0; #2;
    cyc(); reset_n = 1'b1; exp_ptr = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear_reqs(); flush = 1'b0; resp_ready = 1'b0;
    #3;
    chk_cnt++;
    if ({busy, resp_valid, st_align_en, st_add_en, st_norm_en, st_round_en, req0_ready, req1_ready,
         dp_sub, dp_rm, resp_src, resp_fflags, resp_tag} !== '0)
      $display("FAIL reset_ctrl got busy=%b rv=%b en=%b%b%b%b", busy, resp_valid, st_align_en,
               st_add_en, st_norm_en, st_round_en);
    else pass_cnt++;
    chk_cnt++;
    if ({dp_a, dp_b, resp_result} !== '0)
      $display("FAIL reset_data got a=%h b=%h res=%h exp 0", dp_a, dp_b, resp_result);
    else pass_cnt++;
    cyc(); reset_n = 1'b1; exp_ptr = 1'b0;
  endtask

  task automatic test_normal;
    addsub_req_t r;
    logic [3:0]  exp_en [1:4];
    exp_en[1] = 4'b1000; exp_en[2] = 4'b0100; exp_en[3] = 4'b0010; exp_en[4] = 4'b0001;
    r.a = 32'h3F800000; r.b = 32'h40000000; r.sub = 1'b0; r.rm = RM_RNE; r.tag = 5'd3;
    cyc(); drive_req(0, r); resp_ready = 1'b0;
    smp();
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL normal_ready got=%b exp=10", {req0_ready, req1_ready});
    else pass_cnt++;
    exp_ptr = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc(); clear_reqs();
      smp();
      chk_cnt++;
      if ({resp_valid, st_align_en, st_add_en, st_norm_en, st_round_en} !== {1'b0, exp_en[c]})
        $display("FAIL normal_stage%0d got=%b%b%b%b%b exp=0%b", c, resp_valid, st_align_en, st_add_en,
                 st_norm_en, st_round_en, exp_en[c]);
      else pass_cnt++;
      if (c == 1) begin
        chk_cnt++;
        if ({dp_a, dp_b, dp_sub} !== {r.a, r.b, r.sub})
          $display("FAIL normal_operands got a=%h b=%h exp a=%h b=%h", dp_a, dp_b, r.a, r.b);
        else pass_cnt++;
      end
    end
    cyc(); resp_ready = 1'b1;
    smp();
    chk_cnt++;
    if ({resp_valid, resp_result, resp_fflags, resp_tag, resp_src} !== {1'b1, 32'h40400000, 5'd0, 5'd3, 1'b0})
      $display("FAIL normal_resp got v=%b res=%h fl=%h tag=%0d src=%b exp 1 40400000 0 3 0",
               resp_valid, resp_result, resp_fflags, resp_tag, resp_src);
    else pass_cnt++;
    cyc(); resp_ready = 1'b0;
    smp();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL normal_idle got busy=%b exp=0", busy);
    else pass_cnt++;
  endtask

  task automatic test_arbitration;
    addsub_req_t r0, r1;
    int          win, k;
    do_reset();
    rand_req(r0, 1'b0); rand_req(r1, 1'b0);
    r0.tag = 5'd10; r1.tag = 5'd20;
    drive_req(0, r0); drive_req(1, r1); resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      win = rr_pick(1'b1, 1'b1, exp_ptr);
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'(1 << win) || win != (i % 2))
        $display("FAIL arb_grant%0d got r0=%b r1=%b exp port %0d", i, req0_ready, req1_ready, i % 2);
      else pass_cnt++;
      exp_ptr = (win == 0);
      k = 0;
      do begin
        cyc(); smp(); k++;
        if (!resp_valid) begin
          chk_cnt++;
          if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL arb_busy_ready got=%b%b exp=00", req0_ready, req1_ready);
          else pass_cnt++;
        end
      end while (!resp_valid && k < 8);
      chk_cnt++;
      if (k != 5 || resp_src !== 1'(win) || resp_tag !== (win == 0 ? r0.tag : r1.tag))
        $display("FAIL arb_resp%0d got lat=%0d src=%b tag=%0d exp lat=5 src=%0d", i, k, resp_src, resp_tag, win);
      else pass_cnt++;
      cyc();
    end
    clear_reqs(); resp_ready = 1'b0;
    smp();
  endtask

  task automatic test_special;
    addsub_req_t r;
    bit          seen;
    seen = 1'b0;
    r.a = 32'h7FC00000; r.b = 32'h3F800000; r.sub = 1'b0; r.rm = RM_RNE; r.tag = 5'd7;
    cyc(); drive_req(0, r); resp_ready = 1'b0;
    smp();
    chk_cnt++;
    if (req0_ready !== 1'b1) $display("FAIL special_ready got=%b exp=1", req0_ready);
    else pass_cnt++;
    exp_ptr = 1'b1;
    cyc(); clear_reqs(); smp();
    seen |= st_add_en | st_norm_en | st_round_en;
    chk_cnt++;
    if ({st_align_en, resp_valid} !== 2'b10) $display("FAIL special_align got en=%b rv=%b exp 1 0", st_align_en, resp_valid);
    else pass_cnt++;
    cyc(); smp();
    seen |= st_add_en | st_norm_en | st_round_en;
    chk_cnt++;
    if ({resp_valid, resp_result, resp_fflags, resp_tag} !== {1'b1, 32'h7FC00000, 5'd0, 5'd7})
      $display("FAIL special_resp got v=%b res=%h fl=%h tag=%0d exp 1 7fc00000 0 7", resp_valid, resp_result,
               resp_fflags, resp_tag);
    else pass_cnt++;
    cyc(); resp_ready = 1'b1; smp();
    seen |= st_add_en | st_norm_en | st_round_en;
    cyc(); resp_ready = 1'b0; smp();
    chk_cnt++;
    if (seen || busy !== 1'b0) $display("FAIL special_no_stages got seen=%b busy=%b exp 0 0", seen, busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    addsub_req_t r, r0;
    logic [36:0] e;
    int          k;
    rand_req(r, 1'b0); rand_req(r0, 1'b0);
    e = dp_model(r.a, r.b, r.sub, r.rm);
    cyc(); drive_req(1, r); resp_ready = 1'b0;
    smp();
    exp_ptr = 1'b0;
    k = 0;
    do begin
      cyc(); clear_reqs(); smp(); k++;
    end while (!resp_valid && k < 10);
    chk_cnt++;
    if (k != 5) $display("FAIL bp_latency got=%0d exp=5", k);
    else pass_cnt++;
    for (int s = 0; s < 4; s++) begin
      cyc(); drive_req(0, r0); smp();
      chk_cnt++;
      if ({resp_valid, resp_result, resp_fflags, resp_tag, resp_src, req0_ready} !== {1'b1, e[31:0], e[36:32], r.tag, 1'b1, 1'b0})
        $display("FAIL bp_hold%0d got v=%b res=%h fl=%h tag=%0d src=%b rdy=%b exp res=%h", s, resp_valid,
                 resp_result, resp_fflags, resp_tag, resp_src, req0_ready, e[31:0]);
      else pass_cnt++;
    end
    cyc(); clear_reqs(); resp_ready = 1'b1; smp();
    cyc(); resp_ready = 1'b0; smp();
    chk_cnt++;
    if ({busy, resp_valid} !== 2'b00) $display("FAIL bp_release got busy=%b rv=%b exp 0 0", busy, resp_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush;
    addsub_req_t r, r1;
    logic [36:0] e;
    int          k, win;
    rand_req(r, 1'b0); rand_req(r1, 1'b0);
    r.tag = 5'd1; r1.tag = 5'd2;
    e = dp_model(r1.a, r1.b, r1.sub, r1.rm);
    cyc(); drive_req(0, r); resp_ready = 1'b1; smp();
    exp_ptr = 1'b1;
    cyc(); clear_reqs(); smp();
    cyc(); flush = 1'b1; smp();
    chk_cnt++;
    if (st_add_en !== 1'b1) $display("FAIL flush_in_add got add_en=%b exp=1", st_add_en);
    else pass_cnt++;
    cyc(); flush = 1'b0; drive_req(1, r1); smp();
    chk_cnt++;
    if ({busy, resp_valid, req1_ready} !== 3'b001) $display("FAIL flush_idle got busy=%b rv=%b rdy1=%b exp 0 0 1",
                                                           busy, resp_valid, req1_ready);
    else pass_cnt++;
    exp_ptr = 1'b0;
    k = 0;
    do begin
      cyc(); clear_reqs(); smp(); k++;
    end while (!resp_valid && k < 10);
    chk_cnt++;
    if (k != 5 || resp_tag !== r1.tag || resp_result !== e[31:0])
      $display("FAIL flush_next_op got lat=%0d tag=%0d res=%h exp lat=5 tag=%0d res=%h", k, resp_tag,
               resp_result, r1.tag, e[31:0]);
    else pass_cnt++;
    cyc(); resp_ready = 1'b0; drive_req(0, r); flush = 1'b1; smp();
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL flush_blocks_accept got=%b%b exp=00", req0_ready, req1_ready);
    else pass_cnt++;
    cyc(); flush = 1'b0; smp();
    exp_ptr = 1'b1;
    cyc(); clear_reqs(); resp_ready = 1'b1;
    k = 0;
    do begin
      smp(); k++;
      if (!resp_valid) cyc();
    end while (!resp_valid && k < 10);
    cyc(); flush = 1'b1; resp_ready = 1'b1; smp();
    cyc(); flush = 1'b0; resp_ready = 1'b0; drive_req(0, r); drive_req(1, r1); smp();
    win = rr_pick(1'b1, 1'b1, exp_ptr);
    chk_cnt++;
    if (resp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'(1 << win))
      $display("FAIL flush_done got rv=%b r0=%b r1=%b exp rv=0 port %0d", resp_valid, req0_ready, req1_ready, win);
    else pass_cnt++;
    exp_ptr = (win == 0);
    cyc(); clear_reqs(); flush = 1'b1; smp();
    cyc(); flush = 1'b0; smp();
  endtask

  task automatic test_async_reset;
    addsub_req_t r0, r1;
    int          k;
    rand_req(r0, 1'b0); rand_req(r1, 1'b0);
    r0.tag = 5'd12; r1.tag = 5'd25;
    cyc(); drive_req(0, r0); smp();
    cyc(); clear_reqs(); smp();
    cyc(); smp();
    cyc(); smp();
    chk_cnt++;
    if (st_norm_en !== 1'b1) $display("FAIL rst_in_norm got norm_en=%b exp=1", st_norm_en);
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, resp_valid, st_align_en, st_add_en, st_norm_en, st_round_en, dp_a, dp_b, resp_result, resp_tag} !== '0)
      $display("FAIL rst_async got busy=%b en=%b%b%b%b a=%h exp all 0", busy, st_align_en, st_add_en,
               st_norm_en, st_round_en, dp_a);
    else pass_cnt++;
    cyc(); cyc(); reset_n = 1'b1; exp_ptr = 1'b0;
    drive_req(0, r0); drive_req(1, r1); resp_ready = 1'b1; smp();
    chk_cnt++;
    if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_priority got=%b%b exp=10", req0_ready, req1_ready);
    else pass_cnt++;
    exp_ptr = 1'b1;
    k = 0;
    do begin
      cyc(); clear_reqs(); smp(); k++;
    end while (!resp_valid && k < 10);
    chk_cnt++;
    if (k != 5 || resp_tag !== r0.tag || resp_src !== 1'b0)
      $display("FAIL rst_after_resp got lat=%0d tag=%0d src=%b exp 5 %0d 0", k, resp_tag, resp_src, r0.tag);
    else pass_cnt++;
    cyc(); resp_ready = 1'b0; smp();
  endtask

  task automatic test_random;
    addsub_req_t r0, r1, rw;
    logic [36:0] e;
    int          pat, win, k, bp;
    for (int n = 0; n < 30; n++) begin
      rand_req(r0, $urandom_range(0, 5) == 0);
      rand_req(r1, $urandom_range(0, 5) == 0);
      pat = $urandom_range(1, 3);
      cyc(); resp_ready = 1'b0;
      if (pat[0]) drive_req(0, r0);
      if (pat[1]) drive_req(1, r1);
      smp();
      win = rr_pick(pat[0], pat[1], exp_ptr);
      rw  = (win == 0) ? r0 : r1;
      e   = dp_model(rw.a, rw.b, rw.sub, rw.rm);
      chk_cnt++;
      if ({req1_ready, req0_ready} !== 2'(1 << win))
        $display("FAIL rand_grant%0d got r0=%b r1=%b exp port %0d", n, req0_ready, req1_ready, win);
      else pass_cnt++;
      exp_ptr = (win == 0);
      k = 0;
      do begin
        cyc(); clear_reqs(); smp(); k++;
      end while (!resp_valid && k < 10);
      chk_cnt++;
      if (k != exp_latency(rw) || {resp_result, resp_fflags, resp_tag, resp_src} !== {e[31:0], e[36:32], rw.tag, 1'(win)})
        $display("FAIL rand_resp%0d got lat=%0d res=%h fl=%h tag=%0d src=%b exp lat=%0d res=%h fl=%h tag=%0d src=%0d",
                 n, k, resp_result, resp_fflags, resp_tag, resp_src, exp_latency(rw), e[31:0], e[36:32], rw.tag, win);
      else pass_cnt++;
      bp = $urandom_range(0, 3);
      for (int s = 0; s < bp; s++) begin
        cyc(); smp();
      end
      chk_cnt++;
      if (resp_valid !== 1'b1) $display("FAIL rand_hold%0d got rv=%b exp=1", n, resp_valid);
      else pass_cnt++;
      cyc(); resp_ready = 1'b1; smp();
    end
    cyc(); resp_ready = 1'b0; smp();
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0; req0_rm = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0; req1_rm = '0; req1_tag = '0;
    test_reset();
    test_normal();
    test_arbitration();
    test_special();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
